// File: rtl/div_ctrl.sv
// div_ctrl: sequencing front-end for the 64-bit iterative unsigned divider.
// Accepts RV64M DIV/DIVU/REM/REMU (and W forms), feeds unsigned magnitudes to
// the core, applies sign/width fix-up and returns one result to writeback.
// Optional feature macro: DIV_FASTPATH_EN -- when defined, divide-by-zero and
// signed overflow skip the core and complete one cycle after accept.
`timescale 1ns/1ps
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_word,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        div_en,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  input  logic [63:0] div_quotient,
  input  logic [63:0] div_remainder,
  input  logic        div_compl
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

`ifdef DIV_FASTPATH_EN
  localparam logic FAST_EN = 1'b1;
`else
  localparam logic FAST_EN = 1'b0;
`endif

  // W-form results keep bits [31:0] and sign-extend them.
  function automatic logic [63:0] wfix(input logic w, input logic [63:0] x);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  state_t      state_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        rem_reg;
  logic        word_reg;
  logic        special_reg;
  logic [63:0] special_res_reg;

  logic        op_signed;
  logic        op_rem;
  logic        sa;
  logic        sb;
  logic        b_zero;
  logic        ovf;
  logic        special;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] a_mag;
  logic [63:0] b_mag;
  logic [63:0] min_neg;
  logic [63:0] special_res;
  logic [63:0] q_fix;
  logic [63:0] r_fix;
  logic [63:0] core_res;

  // Operand preparation on the incoming request: width extension, magnitudes,
  // and detection/valuation of the two special cases.
  always_comb begin
    op_signed = ~in_op[0];
    op_rem    = in_op[1];
    if (in_word) begin
      a_ext = op_signed ? {{32{in_a[31]}}, in_a[31:0]} : {32'd0, in_a[31:0]};
      b_ext = op_signed ? {{32{in_b[31]}}, in_b[31:0]} : {32'd0, in_b[31:0]};
    end else begin
      a_ext = in_a;
      b_ext = in_b;
    end
    sa      = op_signed & a_ext[63];
    sb      = op_signed & b_ext[63];
    a_mag   = sa ? (~a_ext + 64'd1) : a_ext;
    b_mag   = sb ? (~b_ext + 64'd1) : b_ext;
    // Most-negative value at the operation width, as its 64-bit extension.
    min_neg = in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    b_zero  = (b_ext == 64'd0);
    ovf     = op_signed & (a_ext == min_neg) & (b_ext == {64{1'b1}});
    special = b_zero | ovf;
    if (b_zero) begin
      special_res = op_rem ? wfix(in_word, a_ext) : {64{1'b1}};
    end else begin
      special_res = op_rem ? 64'd0 : wfix(in_word, a_ext);
    end
  end

  // Sign and width fix-up of the core's unsigned quotient/remainder.
  always_comb begin
    q_fix    = neg_q_reg ? (~div_quotient + 64'd1) : div_quotient;
    r_fix    = neg_r_reg ? (~div_remainder + 64'd1) : div_remainder;
    core_res = wfix(word_reg, rem_reg ? r_fix : q_fix);
  end

  // Control FSM with registered handshake, core-load and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      out_result      <= 64'd0;
      div_en          <= 1'b0;
      div_dividend    <= 64'd0;
      div_divisor     <= 64'd0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      rem_reg         <= 1'b0;
      word_reg        <= 1'b0;
      special_reg     <= 1'b0;
      special_res_reg <= 64'd0;
    end else if (flush) begin
      // The core keeps running; the next div_en pulse reloads it.
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      div_en    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            neg_q_reg       <= sa ^ sb;
            neg_r_reg       <= sa;
            rem_reg         <= op_rem;
            word_reg        <= in_word;
            special_reg     <= special;
            special_res_reg <= special_res;
            div_dividend    <= a_mag;
            div_divisor     <= b_mag;
            in_ready        <= 1'b0;
            if (FAST_EN && special) begin
              state_reg  <= DONE;
              out_valid  <= 1'b1;
              out_result <= special_res;
            end else begin
              state_reg <= ISSUE;
              div_en    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // div_compl may still be high from the previous op; not sampled here.
          div_en    <= 1'b0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (div_compl) begin
            out_result <= special_reg ? special_res_reg : core_res;
            out_valid  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a behavioural model of the
// 64-cycle iterative divider core. Honours DIV_FASTPATH_EN for latencies.
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  // Edges counted after the accept edge until out_valid is seen.
  localparam int LAT_CORE = 66;
`ifdef DIV_FASTPATH_EN
  localparam int LAT_SPECIAL = 0;   // out_valid already high in the cycle after accept
`else
  localparam int LAT_SPECIAL = 66;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic        in_word = 1'b0;
  logic [63:0] in_a = 64'd0;
  logic [63:0] in_b = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        div_en;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic [63:0] div_quotient = 64'd0;
  logic [63:0] div_remainder = 64'd0;
  logic        div_compl = 1'b0;

  int checks = 0;
  int failures = 0;

  div_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_word      (in_word),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .div_en       (div_en),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_compl    (div_compl)
  );

  always #5 clk = ~clk;

  // Core model: loads on div_en, 64 iteration edges, then div_compl stays high.
  logic [63:0] core_a = 64'd0;
  logic [63:0] core_b = 64'd0;
  int          core_cnt = 0;
  always @(posedge clk) begin
    if (div_en) begin
      core_a    <= div_dividend;
      core_b    <= div_divisor;
      core_cnt  <= 64;
      div_compl <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        div_compl <= 1'b1;
        if (core_b == 64'd0) begin
          div_quotient  <= {64{1'b1}};
          div_remainder <= core_a;
        end else begin
          div_quotient  <= core_a / core_b;
          div_remainder <= core_a % core_b;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; checks latency,
  // number of core load pulses and the result. Leaves the result in DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int pulses;
    @(negedge clk);
    check($sformatf("%s.ready", tag), 64'(in_ready), 64'd1);
    in_op = op; in_word = w; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("%s.busy", tag), 64'(in_ready), 64'd0);
    lat = 0;
    pulses = 0;
    while (!out_valid && lat < 200) begin
      if (div_en) pulses++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s.lat", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.pulses", tag), 64'(pulses), (exp_lat == 0) ? 64'd0 : 64'd1);
    check($sformatf("%s.valid", tag), 64'(out_valid), 64'd1);
    check($sformatf("%s.result", tag), out_result, exp_res);
    $display("op %s: op=%0d w=%0d a=0x%h b=0x%h result=0x%h lat=%0d", tag, op, w, a, b, out_result, lat);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s.hs_valid", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s.hs_ready", tag), 64'(in_ready), 64'd1);
  endtask

  task automatic op(input string tag, input logic [1:0] opc, input logic w,
                    input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] exp_res, input int exp_lat);
    run_op(tag, opc, w, a, b, exp_res, exp_lat);
    handshake(tag);
  endtask

  initial begin
    int seen;
    // Reset state
    #2;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_result", out_result, 64'd0);
    check("rst.div_en", 64'(div_en), 64'd0);
    check("rst.dividend", div_dividend, 64'd0);
    check("rst.divisor", div_divisor, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);

    // Core-path arithmetic
    op("divu", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, LAT_CORE);
    op("remu", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, LAT_CORE);
    op("div_neg", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_CORE);
    op("rem_neg", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_CORE);
    op("divw", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_CORE);
    op("div_negb", OP_DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, LAT_CORE);
    op("rem_negb", OP_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, LAT_CORE);
    op("divuw", OP_DIVU, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'd16, 64'h0000_0000_0FFF_FFFF, LAT_CORE);
    op("remw", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h1234_5678_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, LAT_CORE);
    op("divuw_nov", OP_DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LAT_CORE);

    // Special cases
    op("div_z", OP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SPECIAL);
    op("rem_z", OP_REM, 1'b0, 64'd5, 64'd0, 64'd5, LAT_SPECIAL);
    op("remuw_z", OP_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h1111_1111_0000_0000, 64'hFFFF_FFFF_8000_0005, LAT_SPECIAL);
    op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, LAT_SPECIAL);
    op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LAT_SPECIAL);
    op("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LAT_SPECIAL);
    op("remw_ovf", OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, LAT_SPECIAL);

    // Backpressure: result held while out_ready is low
    run_op("bp", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, LAT_CORE);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.hold_result", out_result, 64'd14);
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_ready", 64'(in_ready), 64'd0);
    end
    handshake("bp");
    op("b2b", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, LAT_CORE);

    // Flush 20 cycles into WAIT
    @(negedge clk);
    in_op = OP_DIVU; in_word = 1'b0; in_a = 64'd100; in_b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.in_ready", 64'(in_ready), 64'd1);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.div_en", 64'(div_en), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush.no_valid", 64'(seen), 64'd0);
    $display("op flush: in-flight DIVU discarded, out_valid cycles=%0d", seen);
    op("flush_next", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, LAT_CORE);

    // Asynchronous reset mid-WAIT
    @(negedge clk);
    in_op = OP_DIVU; in_word = 1'b0; in_a = 64'd100; in_b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.out_result", out_result, 64'd0);
    check("arst.div_en", 64'(div_en), 64'd0);
    check("arst.dividend", div_dividend, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("arst.in_ready", 64'(in_ready), 64'd1);
    $display("op reset: mid-WAIT reset applied, in_ready=%0d", in_ready);
    op("post_rst", OP_DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, LAT_CORE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing front-end for the 64-bit iterative unsigned divider core in the execute stage. It accepts RV64M division requests (DIV, DIVU, REM, REMU and the W forms) over a valid/ready handshake and converts signed operands to magnitudes. It drives the core's load/complete protocol, applies sign and width fix-up, and returns one 64-bit result to writeback over a second valid/ready handshake. Special cases (divide-by-zero, signed overflow) are resolved locally.

## Interface
- No parameters; datapath fixed at 64 bits.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; returns block to IDLE
- in_valid  in  1  request present
- in_ready  out  1  block can accept (high only in IDLE)
- in_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- in_word  in  1  W form: 32-bit operation, result sign-extended
- in_a  in  64  dividend
- in_b  in  64  divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  64  quotient or remainder, RV64M semantics
- div_en  out  1  one-cycle load pulse to core
- div_dividend  out  64  unsigned magnitude to core
- div_divisor  out  64  unsigned magnitude to core
- div_quotient  in  64  core quotient
- div_remainder  in  64  core remainder
- div_compl  in  1  core done flag (stays high until next load)

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, capture operands and op, then go to ISSUE (or DONE on fast path).
- Operand prep at accept:
  - W form: a32/b32 = low 32 bits, sign-extended for DIV/REM, zero-extended for DIVU/REMU.
  - Signed ops: magnitudes = two's-complement absolute values.
  - Latch neg_q = sa^sb and neg_r = sa.
- ISSUE: div_en=1 for exactly one cycle with registered magnitudes, then WAIT.
- WAIT: div_compl is ignored in the ISSUE cycle and sampled only in WAIT (it may be stale from a prior operation in ISSUE). When div_compl=1, register the fixed-up result and go to DONE.
- Fix-up:
  - Quotient negated if neg_q and divisor≠0.
  - Remainder negated if neg_r.
  - W form: take bits [31:0], sign-extend to 64.
- Special-case results, identical in both configurations:
  - Divisor 0: quotient = all ones (W: sign-extended 0xFFFFFFFF); remainder = dividend (W: sext of a[31:0]).
  - Signed overflow (a = most-negative, b = −1, at operation width): quotient = a; remainder = 0.
- DONE: out_valid=1 and out_result held stable until out_ready. On out_valid&out_ready go to IDLE. No new request is accepted in the same cycle.
- flush: in any state forces IDLE next edge, drops out_valid, and discards any in-flight result. The core is not reset; its next div_en reloads it. flush has priority over accept and completion in the same cycle.
- Reset values: state=IDLE, out_valid=0, out_result=0, in_ready=1 after reset deasserts, div_en=0, div_dividend=0, div_divisor=0.

## Timing
- Core path: accept edge E0 → ISSUE cycle → core loads at E1 → 64 iteration edges (E2–E65) → div_compl high after E65 → result registered at E66. out_valid is high in the cycle after E66: 66 edges from accept to out_valid.
- Fast path (macro on): accept edge E0 registers the special result; out_valid is high in the next cycle (latency 1).
- Throughput: one operation in flight. in_ready is low from the accept edge until the DONE handshake completes.
- Backpressure: DONE holds indefinitely while out_ready=0.

## Configuration
- DIV_FASTPATH_EN defined: divide-by-zero and signed overflow bypass the core and go IDLE→DONE with latency 1. div_en is not pulsed.
- Undefined: every request goes through ISSUE/WAIT with the full 66-cycle latency. Special-case values are still substituted at fix-up, so results are bit-identical.

## Test plan
- DIVU a=100, b=7 → out_result=14 with out_valid exactly 66 cycles after accept. REMU same operands → 2.
- DIV a=−7, b=2 → −3 (0xFFFFFFFFFFFFFFFD). REM same operands → −1. DIVW a=0x00000000FFFFFFF9, b=2 → 0xFFFFFFFFFFFFFFFD.
- DIV a=5, b=0 → 0xFFFFFFFFFFFFFFFF and REM → 5. DIV a=0x8000000000000000, b=−1 → 0x8000000000000000, REM → 0. DIVW a=0x80000000, b=−1 → 0xFFFFFFFF80000000. Latency is 1 with DIV_FASTPATH_EN, 66 without.
- Hold out_ready=0 for 10 cycles in DONE → out_result stable and in_ready=0. Raise out_ready → next-cycle in_ready=1. Back-to-back second op returns a correct result (stale div_compl ignored).
- Assert flush 20 cycles into WAIT → IDLE next cycle and no out_valid. New DIVU 9/3 → 3 after 66 cycles.
- Assert reset mid-WAIT → out_valid=0, out_result=0, div_en=0 immediately; in_ready=1 after reset release.
